// File: rtl/jk_register_bank.sv
// jk_register_bank: WIDTH-bit flip-flop bank with run-time JK/D/T/SR mode, sync clear/set, enable and change statistics.
module jk_register_bank #(
    parameter int              WIDTH = 8,
    parameter int              CNT_W = 16,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             Clock,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             sclr_n,
    input  logic             sset,
    input  logic             stat_clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             changed,
    output logic [CNT_W-1:0] chg_count,
    output logic             sr_err
);
    logic [WIDTH-1:0] q_q, q_d, qbar_q, upd;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chg_q, chg_d, err_q, err_d;

    always_comb begin
        upd   = mode == 2'b00 ? (J & ~q_q) | (~K & q_q) :
                mode == 2'b01 ? J :
                mode == 2'b10 ? J ^ q_q :
                                (J & ~K) | (q_q & (J | ~K));
        q_d   = !sclr_n ? '0 : sset ? '1 : !en ? q_q : upd;
        chg_d = q_d != q_q;
        cnt_d = stat_clr ? '0 : (chg_d && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        err_d = stat_clr ? 1'b0 : err_q | (sclr_n & ~sset & en & (mode == 2'b11) & |(J & K));
    end

    // Qbar is its own register loaded with ~q_d so it tracks Q on every edge.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            q_q    <= INIT;
            qbar_q <= ~INIT;
            chg_q  <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            qbar_q <= ~q_d;
            chg_q  <= chg_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign Q         = q_q;
    assign Qbar      = qbar_q;
    assign changed   = chg_q;
    assign chg_count = cnt_q;
    assign sr_err    = err_q;
endmodule

// File: tb/tb_jk_register_bank.sv
// tb_jk_register_bank: directed checks of the flip-flop bank, with a second narrow-counter instance for saturation.
module tb_jk_register_bank;
    logic        Clock = 1'b0, reset = 1'b0, en = 1'b0, sclr_n = 1'b1, sset = 1'b0, stat_clr = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  J = '0, K = '0;
    logic [7:0]  q1, qb1, q2, qb2;
    logic        ch1, ch2, e1, e2;
    logic [15:0] c1;
    logic [1:0]  c2;
    int          tests = 0, fails = 0;

    jk_register_bank #(.WIDTH(8), .CNT_W(16), .INIT(8'hA5)) dut (
        .Clock(Clock), .reset(reset), .en(en), .mode(mode), .J(J), .K(K),
        .sclr_n(sclr_n), .sset(sset), .stat_clr(stat_clr),
        .Q(q1), .Qbar(qb1), .changed(ch1), .chg_count(c1), .sr_err(e1)
    );

    jk_register_bank #(.WIDTH(8), .CNT_W(2), .INIT(8'h00)) dut_sat (
        .Clock(Clock), .reset(reset), .en(en), .mode(mode), .J(J), .K(K),
        .sclr_n(sclr_n), .sset(sset), .stat_clr(stat_clr),
        .Q(q2), .Qbar(qb2), .changed(ch2), .chg_count(c2), .sr_err(e2)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        chk("reset_q", 16'(q1), 16'hA5);
        chk("reset_qbar", 16'(qb1), 16'h5A);
        chk("reset_cnt", c1, 16'h0);
        chk("reset_changed", 16'(ch1), 16'h0);
        chk("reset_err", 16'(e1), 16'h0);
        @(negedge Clock);
        reset = 1'b0;
    endtask

    task automatic test_jk();
        sclr_n = 1'b0; tick();
        chk("jk_pre_clear_q", 16'(q1), 16'h00);
        chk("jk_pre_clear_changed", 16'(ch1), 16'h1);
        sclr_n = 1'b1; stat_clr = 1'b1; tick();
        chk("jk_statclr_cnt", c1, 16'h0);
        chk("jk_statclr_changed", 16'(ch1), 16'h0);
        stat_clr = 1'b0; en = 1'b1; mode = 2'b00; J = 8'hFF; K = 8'h00; tick();
        chk("jk_set_q", 16'(q1), 16'hFF);
        chk("jk_set_qbar", 16'(qb1), 16'h00);
        chk("jk_set_changed", 16'(ch1), 16'h1);
        K = 8'hFF; tick();
        chk("jk_toggle_q", 16'(q1), 16'h00);
        chk("jk_toggle_changed", 16'(ch1), 16'h1);
        J = 8'h00; K = 8'h00; tick();
        chk("jk_hold_q", 16'(q1), 16'h00);
        chk("jk_hold_changed", 16'(ch1), 16'h0);
        chk("jk_cnt", c1, 16'h2);
    endtask

    task automatic test_sr();
        mode = 2'b01; J = 8'h0F; K = 8'h00; tick();
        chk("sr_pre_d_q", 16'(q1), 16'h0F);
        mode = 2'b11; J = 8'hF0; K = 8'h0F; tick();
        chk("sr_q", 16'(q1), 16'hF0);
        chk("sr_err_clean", 16'(e1), 16'h0);
        J = 8'h01; K = 8'h01; tick();
        chk("sr_illegal_hold_q", 16'(q1), 16'hF0);
        chk("sr_illegal_changed", 16'(ch1), 16'h0);
        chk("sr_err_set", 16'(e1), 16'h1);
        en = 1'b0; tick();
        chk("sr_err_sticky", 16'(e1), 16'h1);
        chk("sr_cnt", c1, 16'h4);
        stat_clr = 1'b1; tick();
        chk("sr_err_cleared", 16'(e1), 16'h0);
        chk("sr_cnt_cleared", c1, 16'h0);
        stat_clr = 1'b0;
    endtask

    task automatic test_clr_set();
        sset = 1'b1; tick();
        chk("set_q", 16'(q1), 16'hFF);
        sclr_n = 1'b0; tick();
        chk("clr_beats_set_q", 16'(q1), 16'h00);
        chk("clr_beats_set_qbar", 16'(qb1), 16'hFF);
        chk("clr_beats_set_changed", 16'(ch1), 16'h1);
        chk("clr_beats_set_cnt", c1, 16'h2);
        sclr_n = 1'b1; en = 1'b1; mode = 2'b11; J = 8'hFF; K = 8'hFF; tick();
        chk("set_override_q", 16'(q1), 16'hFF);
        chk("set_override_no_err", 16'(e1), 16'h0);
        chk("set_override_cnt", c1, 16'h3);
        sset = 1'b0; en = 1'b0;
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [7:0] exp_q   [5] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
        sclr_n = 1'b0; stat_clr = 1'b1; tick();
        chk("sat_init_cnt", 16'(c2), 16'h0);
        sclr_n = 1'b1; stat_clr = 1'b0; mode = 2'b10; J = 8'h01; K = 8'h00; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("sat_cnt_%0d", i), 16'(c2), 16'(exp_cnt[i]));
            chk($sformatf("sat_q_%0d", i), 16'(q2), 16'(exp_q[i]));
        end
        stat_clr = 1'b1; tick();
        chk("sat_statclr_cnt", 16'(c2), 16'h0);
        chk("sat_statclr_q", 16'(q2), 16'h00);
        chk("sat_statclr_changed", 16'(ch2), 16'h1);
        stat_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick();
        chk("mid_toggle_q", 16'(q1), 16'h01);
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_q", 16'(q1), 16'hA5);
        chk("mid_reset_qbar", 16'(qb1), 16'h5A);
        chk("mid_reset_cnt", c1, 16'h0);
        chk("mid_reset_changed", 16'(ch1), 16'h0);
        #1 reset = 1'b0;
        mode = 2'b01; J = 8'h3C; tick();
        chk("after_reset_d_q", 16'(q1), 16'h3C);
        chk("after_reset_d_qbar", 16'(qb1), 16'hC3);
        chk("after_reset_changed", 16'(ch1), 16'h1);
        chk("after_reset_cnt", c1, 16'h1);
    endtask

    initial begin
        test_reset();
        test_jk();
        test_sr();
        test_clr_set();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
